// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the SRAM responder.
// State encoding, latency limits, default base address and byte merge.
package sram_resp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [3:0]  wmask
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (wmask[i]) r[8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Word-wide SRAM array with byte-enable write and registered read.
// Only the index enters; the read word leaves through a register.
module sram_resp_mem
   import sram_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IW          = 10
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [IW-1:0] i_idx,
   input  logic [3:0]    i_wmask,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_idx] <= byte_merge(r_mem[i_idx], i_wdata, i_wmask);
         end else begin
            r_rdata <= r_mem[i_idx];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// Fixed-latency SRAM responder for the data-memory request port.
// One request in flight; response held until the requester takes it.
module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wmask,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int LAT_C = (LATENCY < LAT_MIN) ? LAT_MIN :
                          (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
   localparam logic [3:0] LAT_M1 = 4'(LAT_C - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_wen;
   logic [31:0] r_addr;
   logic [3:0]  r_wmask;
   logic [31:0] r_wdata;
   logic        r_valid;
   logic        r_err;
   logic        r_rsel;

   logic [31:0]   w_off;
   logic          w_inrange;
   logic [IW-1:0] w_idx;
   logic          w_access;
   logic [31:0]   w_mem_rdata;

   // Below-base addresses are rejected before the offset is trusted.
   assign w_off     = r_addr - BASE_ADDR;
   assign w_inrange = (r_addr >= BASE_ADDR) &&
                      ({2'b00, w_off[31:2]} < 32'(DEPTH_WORDS));
   assign w_idx     = w_off[IW+1:2];
   assign w_access  = (r_state == WAIT) && (r_cnt == 4'd0) && !rst;

   sram_resp_mem #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IW          (IW)
   ) u_mem (
      .i_clk   (clk),
      .i_en    (w_access && w_inrange),
      .i_we    (r_wen),
      .i_idx   (w_idx),
      .i_wmask (r_wmask),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_rsel  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_wen   <= req_wen;
                  r_addr  <= req_addr;
                  r_wmask <= req_wmask;
                  r_wdata <= req_wdata;
                  r_cnt   <= LAT_M1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
                  r_valid <= 1'b1;
                  r_err   <= !w_inrange;
                  r_rsel  <= !r_wen && w_inrange;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
                  r_rsel  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE) && !rst;
   assign busy       = (r_state != IDLE);
   assign resp_valid = r_valid;
   assign resp_err   = r_err;
   assign resp_rdata = r_rsel ? w_mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_responder.sv
// Directed and table-driven checks of sram_responder.
// Three instances cover LATENCY 1, 2 and 7.
module tb_sram_responder;

   logic        clk;
   logic        rst;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_wen    [3];
   logic [31:0] req_addr   [3];
   logic [3:0]  req_wmask  [3];
   logic [31:0] req_wdata  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];
   logic        busy       [3];

   int total;
   int bad;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 7;
      sram_responder #(
         .DEPTH_WORDS (1024),
         .BASE_ADDR   (32'h8000_0000),
         .LATENCY     (L)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_wen    (req_wen[g]),
         .req_addr   (req_addr[g]),
         .req_wmask  (req_wmask[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g]),
         .busy       (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic txn(input int d, input int lat, input logic wen,
                      input logic [31:0] addr, input logic [3:0] m,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output time tacc);
      int n;
      n = 0;
      rd = '0;
      er = 1'b0;
      tacc = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("ready_timeout", {31'd0, req_ready[d]}, 32'd1);
         return;
      end
      req_valid[d] = 1'b1;
      req_wen[d]   = wen;
      req_addr[d]  = addr;
      req_wmask[d] = m;
      req_wdata[d] = wd;
      @(negedge clk);
      tacc = $time - 5;
      req_valid[d] = 1'b0;
      n = 0;
      while (!resp_valid[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency_d%0d", d), n, lat);
      rd = resp_rdata[d];
      er = resp_err[d];
      resp_ready[d] = 1'b1;
      @(negedge clk);
      chk("resp_clear", {31'd0, resp_valid[d]}, 32'd0);
   endtask

   vec_t        vt [12];
   logic [31:0] rd;
   logic        er;
   time         t0;
   time         tp;
   logic [31:0] model [16];

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid[i]  = 1'b0;
         req_wen[i]    = 1'b0;
         req_addr[i]   = '0;
         req_wmask[i]  = '0;
         req_wdata[i]  = '0;
         resp_ready[i] = 1'b1;
      end

      vt[0]  = '{1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
      vt[1]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h8000_0012, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0};
      vt[3]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAA_BEEF, 1'b0};
      vt[4]  = '{1'b1, 32'h8000_0000, 4'hF, 32'h0BAD_C0DE, 32'h0, 1'b0};
      vt[5]  = '{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1};
      vt[6]  = '{1'b0, 32'h8000_1000, 4'h0, 32'h0, 32'h0, 1'b1};
      vt[7]  = '{1'b1, 32'h8000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vt[8]  = '{1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'h0BAD_C0DE, 1'b0};
      vt[9]  = '{1'b1, 32'h8000_0FFC, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
      vt[10] = '{1'b0, 32'h8000_0FFD, 4'h0, 32'h0, 32'h1122_3344, 1'b0};
      vt[11] = '{1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};

      // reset state
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_req_ready", {31'd0, req_ready[1]}, 32'd0);
         chk("rst_resp_valid", {31'd0, resp_valid[1]}, 32'd0);
         chk("rst_busy", {31'd0, busy[1]}, 32'd0);
         chk("rst_rdata", resp_rdata[1], 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, req_ready[1]}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         txn(1, 2, vt[i].wen, vt[i].addr, vt[i].mask, vt[i].wdata,
             rd, er, t0);
         chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      end
      txn(1, 2, 1'b0, 32'h8000_0010, 4'h0, 32'h0, rd, er, t0);
      chk("mask0_unchanged", rd, 32'hDEAA_BEEF);

      // response backpressure with an ignored request pulse
      begin
         int n;
         resp_ready[1] = 1'b0;
         req_valid[1] = 1'b1;
         req_wen[1]   = 1'b0;
         req_addr[1]  = 32'h8000_0010;
         @(negedge clk);
         req_valid[1] = 1'b0;
         n = 0;
         while (!resp_valid[1] && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("bp_latency", n, 2);
         for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, resp_valid[1]}, 32'd1);
            chk("bp_rdata", resp_rdata[1], 32'hDEAA_BEEF);
            chk("bp_err", {31'd0, resp_err[1]}, 32'd0);
            chk("bp_busy", {31'd0, busy[1]}, 32'd1);
            chk("bp_ready", {31'd0, req_ready[1]}, 32'd0);
            if (i == 1) begin
               req_valid[1] = 1'b1;
               req_wen[1]   = 1'b1;
               req_addr[1]  = 32'h8000_0010;
               req_wmask[1] = 4'hF;
               req_wdata[1] = 32'h0;
            end
            if (i == 2) req_valid[1] = 1'b0;
            @(negedge clk);
         end
         resp_ready[1] = 1'b1;
         @(negedge clk);
         chk("bp_release_valid", {31'd0, resp_valid[1]}, 32'd0);
         chk("bp_release_busy", {31'd0, busy[1]}, 32'd0);
         chk("bp_release_ready", {31'd0, req_ready[1]}, 32'd1);
         txn(1, 2, 1'b0, 32'h8000_0010, 4'h0, 32'h0, rd, er, t0);
         chk("bp_pulse_ignored", rd, 32'hDEAA_BEEF);
      end

      // reset during WAIT drops the pending write
      begin
         int seen;
         txn(1, 2, 1'b1, 32'h8000_0020, 4'hF, 32'hCAFE_F00D, rd, er, t0);
         req_valid[1] = 1'b1;
         req_wen[1]   = 1'b1;
         req_addr[1]  = 32'h8000_0020;
         req_wmask[1] = 4'hF;
         req_wdata[1] = 32'h1234_5678;
         @(negedge clk);
         req_valid[1] = 1'b0;
         chk("mid_busy", {31'd0, busy[1]}, 32'd1);
         rst = 1'b1;
         #1;
         chk("mid_rst_ready", {31'd0, req_ready[1]}, 32'd0);
         @(negedge clk);
         rst = 1'b0;
         seen = 0;
         for (int i = 0; i < 10; i++) begin
            if (resp_valid[1]) seen++;
            @(negedge clk);
         end
         chk("mid_no_resp", seen, 0);
         chk("mid_idle", {31'd0, busy[1]}, 32'd0);
         txn(1, 2, 1'b0, 32'h8000_0020, 4'h0, 32'h0, rd, er, t0);
         chk("mid_old_data", rd, 32'hCAFE_F00D);
      end

      // latency sweep against a scoreboard
      for (int d = 0; d < 3; d++) begin
         int lat;
         lat = (d == 0) ? 1 : (d == 1) ? 2 : 7;
         for (int w = 0; w < 16; w++) begin
            model[w] = $urandom;
            txn(d, lat, 1'b1, 32'h8000_0100 + 32'(w * 4), 4'hF, model[w],
                rd, er, t0);
         end
         tp = 0;
         for (int k = 0; k < 50; k++) begin
            logic        wen;
            logic        oor;
            int          w;
            logic [3:0]  m;
            logic [31:0] wd;
            logic [31:0] a;
            wen = 1'($urandom);
            oor = ($urandom_range(0, 9) == 0);
            w   = $urandom_range(0, 15);
            m   = 4'($urandom);
            wd  = $urandom;
            a   = oor ? 32'h8000_1000 + 32'(w * 4) :
                        32'h8000_0100 + 32'(w * 4);
            txn(d, lat, wen, a, m, wd, rd, er, t0);
            if (k > 0) chk($sformatf("period_d%0d", d), 32'((t0 - tp) / 10),
                           32'(lat + 2));
            tp = t0;
            chk($sformatf("sweep_err_d%0d", d), {31'd0, er}, {31'd0, oor});
            if (oor || wen) begin
               chk($sformatf("sweep_wr_rdata_d%0d", d), rd, 32'd0);
            end else begin
               chk($sformatf("sweep_rd_d%0d_w%0d", d, w), rd, model[w]);
            end
            if (wen && !oor) begin
               for (int b = 0; b < 4; b++) begin
                  if (m[b]) model[w][8*b +: 8] = wd[8*b +: 8];
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
